// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, FSM
// state codes, ALU operation codes, mux selects and the control word.
package mips_ctrl_pkg;

    // Opcodes (IR[31:26]) handled by the controller
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // Controller states; codes 12-15 are unused and recover to FETCH
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_e;

    // ALU operation requests
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;

    // ALU B operand select
    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // Next-PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Everything the datapath needs from the controller in one cycle
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctrl_word_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational output decoder: maps the current state (and mem_ready for
// the handshake states) to the datapath control word.
module mc_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_e     state,
    input  logic       mem_ready,
    output ctrl_word_t ctrl
);

    // Decode the control word for the current state
    always_comb begin
        // NOTE: the whole word is defaulted first so no state path can infer a latch.
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.iord      = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
                // IR and PC only advance once the instruction word arrives
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                // Precompute the branch target while the opcode is decoded
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_RWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_RT;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_ADDIWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b0;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: holds the state register and next-state
// logic, derives pc_en and illegal_op, and forces all outputs low in reset.
module multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       pc_en,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUop,
    output logic [1:0] PCSource,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_e     state_q;
    state_e     state_d;
    logic       illegal_d;
    ctrl_word_t ctrl_raw;
    ctrl_word_t ctrl;

    // Next-state selection and illegal-opcode detection
    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_RWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // State register with synchronous reset to FETCH
    always_ff @(posedge clk) begin
        // NOTE: sequential state takes non-blocking assignments; the comb block above uses blocking.
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    mc_ctrl_outdec u_outdec (
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl_raw)
    );

    // Reset wins over every decoded output so an abandoned access stops at once
    assign ctrl = reset ? '0 : ctrl_raw;

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign pc_en       = ctrl.pc_write | (ctrl.pc_write_cond & zero);
    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUop       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;
    assign instr_done  = ctrl.instr_done;
    assign illegal_op  = illegal_d & ~reset;
    assign state       = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver pushes the hand-computed
// output vector for each cycle it drives; the monitor pops and compares it
// mid-cycle on the falling edge.
module tb_multicycle_ctrl;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, pc_en, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, instr_done, illegal_op;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUop;
    logic [3:0] state;

    multicycle_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .pc_en       (pc_en),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUop       (ALUop),
        .PCSource    (PCSource),
        .instr_done  (instr_done),
        .illegal_op  (illegal_op),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector layout, MSB first:
    // PCWrite PCWriteCond pc_en IorD MemRead MemWrite IRWrite MemtoReg RegDst
    // RegWrite ALUSrcA ALUSrcB[2] ALUop[3] PCSource[2] instr_done illegal_op state[4]
    localparam logic [23:0] B_PCW   = 24'd1 << 23;
    localparam logic [23:0] B_PCWC  = 24'd1 << 22;
    localparam logic [23:0] B_PCEN  = 24'd1 << 21;
    localparam logic [23:0] B_IORD  = 24'd1 << 20;
    localparam logic [23:0] B_MRD   = 24'd1 << 19;
    localparam logic [23:0] B_MWR   = 24'd1 << 18;
    localparam logic [23:0] B_IRW   = 24'd1 << 17;
    localparam logic [23:0] B_M2R   = 24'd1 << 16;
    localparam logic [23:0] B_RDST  = 24'd1 << 15;
    localparam logic [23:0] B_RWR   = 24'd1 << 14;
    localparam logic [23:0] B_SRCA  = 24'd1 << 13;
    localparam logic [23:0] SB_FOUR = 24'd1 << 11;
    localparam logic [23:0] SB_IMM  = 24'd2 << 11;
    localparam logic [23:0] SB_SH2  = 24'd3 << 11;
    localparam logic [23:0] AO_SUB  = 24'd1 << 8;
    localparam logic [23:0] AO_FN   = 24'd2 << 8;
    localparam logic [23:0] PS_OUT  = 24'd1 << 6;
    localparam logic [23:0] PS_JMP  = 24'd2 << 6;
    localparam logic [23:0] B_DONE  = 24'd1 << 5;
    localparam logic [23:0] B_ILL   = 24'd1 << 4;

    // Hand-written expected vectors, one per state/condition
    localparam logic [23:0] E_ZERO       = 24'd0;
    localparam logic [23:0] E_FETCH_WAIT = B_MRD | SB_FOUR | 24'd0;
    localparam logic [23:0] E_FETCH_GO   = B_MRD | SB_FOUR | B_IRW | B_PCW | B_PCEN | 24'd0;
    localparam logic [23:0] E_DECODE     = SB_SH2 | 24'd1;
    localparam logic [23:0] E_DECODE_ILL = SB_SH2 | B_ILL | 24'd1;
    localparam logic [23:0] E_MEMADR     = B_SRCA | SB_IMM | 24'd2;
    localparam logic [23:0] E_MEMRD      = B_MRD | B_IORD | 24'd3;
    localparam logic [23:0] E_MEMWB      = B_RWR | B_M2R | B_DONE | 24'd4;
    localparam logic [23:0] E_MEMWR_WAIT = B_MWR | B_IORD | 24'd5;
    localparam logic [23:0] E_MEMWR_GO   = B_MWR | B_IORD | B_DONE | 24'd5;
    localparam logic [23:0] E_EXEC       = B_SRCA | AO_FN | 24'd6;
    localparam logic [23:0] E_RWB        = B_RWR | B_RDST | B_DONE | 24'd7;
    localparam logic [23:0] E_BR_TAKEN   = B_SRCA | AO_SUB | B_PCWC | PS_OUT | B_DONE | B_PCEN | 24'd8;
    localparam logic [23:0] E_BR_NOT     = B_SRCA | AO_SUB | B_PCWC | PS_OUT | B_DONE | 24'd8;
    localparam logic [23:0] E_JUMP       = B_PCW | B_PCEN | PS_JMP | B_DONE | 24'd9;
    localparam logic [23:0] E_ADDIEX     = B_SRCA | SB_IMM | 24'd10;
    localparam logic [23:0] E_ADDIWB     = B_RWR | B_DONE | 24'd11;

    typedef struct {
        string       name;
        logic [23:0] exp;
    } exp_t;

    exp_t scoreboard[$];
    int   n_compared;
    int   n_mismatched;

    logic [23:0] observed;
    assign observed = {PCWrite, PCWriteCond, pc_en, IorD, MemRead, MemWrite, IRWrite,
                       MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSource,
                       instr_done, illegal_op, state};

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %06h expected %06h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge and queue its expectation
    task automatic step(input string name, input logic rst, input logic [5:0] opc,
                        input logic mr, input logic z, input logic [23:0] exp);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = rst;
        op        = opc;
        mem_ready = mr;
        zero      = z;
        e.name    = name;
        e.exp     = exp;
        scoreboard.push_back(e);
    endtask

    // Monitor: compare whatever is pending mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (scoreboard.size() > 0) begin
                e = scoreboard.pop_front();
                check(e.name, observed, e.exp);
            end
        end
    end

    // Watchdog: the run must always reach its summary
    initial begin
        #200000;
        n_mismatched++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        reset        = 1'b1;
        op           = 6'b000000;
        mem_ready    = 1'b1;
        zero         = 1'b0;

        // Reset: every output low
        step("reset_0", 1'b1, 6'b000000, 1'b1, 1'b0, E_ZERO);
        step("reset_1", 1'b1, 6'b000000, 1'b1, 1'b0, E_ZERO);

        // R-type: 0,1,6,7
        step("r_fetch",  1'b0, 6'b000000, 1'b1, 1'b0, E_FETCH_GO);
        step("r_decode", 1'b0, 6'b000000, 1'b1, 1'b0, E_DECODE);
        step("r_exec",   1'b0, 6'b000000, 1'b1, 1'b0, E_EXEC);
        step("r_wb",     1'b0, 6'b000000, 1'b1, 1'b0, E_RWB);

        // lw with a FETCH wait and two MEMRD waits
        step("lw_fetch_wait", 1'b0, 6'b100011, 1'b0, 1'b0, E_FETCH_WAIT);
        step("lw_fetch",      1'b0, 6'b100011, 1'b1, 1'b0, E_FETCH_GO);
        step("lw_decode",     1'b0, 6'b100011, 1'b1, 1'b0, E_DECODE);
        step("lw_memadr",     1'b0, 6'b100011, 1'b1, 1'b0, E_MEMADR);
        step("lw_memrd_w0",   1'b0, 6'b100011, 1'b0, 1'b0, E_MEMRD);
        step("lw_memrd_w1",   1'b0, 6'b100011, 1'b0, 1'b0, E_MEMRD);
        step("lw_memrd_go",   1'b0, 6'b100011, 1'b1, 1'b0, E_MEMRD);
        step("lw_memwb",      1'b0, 6'b100011, 1'b1, 1'b0, E_MEMWB);

        // sw: 4 cycles, no register write
        step("sw_fetch",  1'b0, 6'b101011, 1'b1, 1'b0, E_FETCH_GO);
        step("sw_decode", 1'b0, 6'b101011, 1'b1, 1'b0, E_DECODE);
        step("sw_memadr", 1'b0, 6'b101011, 1'b1, 1'b0, E_MEMADR);
        step("sw_memwr",  1'b0, 6'b101011, 1'b1, 1'b0, E_MEMWR_GO);

        // beq taken, then not taken (zero high outside BRANCH must not matter)
        step("beq1_fetch",  1'b0, 6'b000100, 1'b1, 1'b0, E_FETCH_GO);
        step("beq1_decode", 1'b0, 6'b000100, 1'b1, 1'b0, E_DECODE);
        step("beq1_branch", 1'b0, 6'b000100, 1'b1, 1'b1, E_BR_TAKEN);
        step("beq0_fetch",  1'b0, 6'b000100, 1'b1, 1'b1, E_FETCH_GO);
        step("beq0_decode", 1'b0, 6'b000100, 1'b1, 1'b1, E_DECODE);
        step("beq0_branch", 1'b0, 6'b000100, 1'b1, 1'b0, E_BR_NOT);

        // Illegal opcode, then jump
        step("ill_fetch",  1'b0, 6'b111111, 1'b1, 1'b0, E_FETCH_GO);
        step("ill_decode", 1'b0, 6'b111111, 1'b1, 1'b0, E_DECODE_ILL);
        step("j_fetch",    1'b0, 6'b000010, 1'b1, 1'b0, E_FETCH_GO);
        step("j_decode",   1'b0, 6'b000010, 1'b1, 1'b0, E_DECODE);
        step("j_jump",     1'b0, 6'b000010, 1'b1, 1'b0, E_JUMP);

        // addi: 0,1,10,11
        step("addi_fetch",  1'b0, 6'b001000, 1'b1, 1'b0, E_FETCH_GO);
        step("addi_decode", 1'b0, 6'b001000, 1'b1, 1'b0, E_DECODE);
        step("addi_ex",     1'b0, 6'b001000, 1'b1, 1'b0, E_ADDIEX);
        step("addi_wb",     1'b0, 6'b001000, 1'b1, 1'b0, E_ADDIWB);

        // Reset in the middle of a stalled sw; MemWrite drops immediately
        step("swr_fetch",   1'b0, 6'b101011, 1'b1, 1'b0, E_FETCH_GO);
        step("swr_decode",  1'b0, 6'b101011, 1'b1, 1'b0, E_DECODE);
        step("swr_memadr",  1'b0, 6'b101011, 1'b1, 1'b0, E_MEMADR);
        step("swr_memwr_w", 1'b0, 6'b101011, 1'b0, 1'b0, E_MEMWR_WAIT);
        step("swr_reset_0", 1'b1, 6'b101011, 1'b0, 1'b0, E_ZERO);
        step("swr_reset_1", 1'b1, 6'b101011, 1'b1, 1'b1, E_ZERO);
        step("swr_reset_2", 1'b1, 6'b101011, 1'b0, 1'b0, E_ZERO);
        step("post_reset_fetch_wait", 1'b0, 6'b101011, 1'b0, 1'b0, E_FETCH_WAIT);
        step("post_reset_fetch",      1'b0, 6'b101011, 1'b1, 1'b0, E_FETCH_GO);
        step("post_reset_decode",     1'b0, 6'b101011, 1'b1, 1'b0, E_DECODE);

        // Let the monitor drain, then confirm nothing is left unchecked
        repeat (3) @(posedge clk);
        n_compared++;
        if (scoreboard.size() != 0) begin
            n_mismatched++;
            $display("FAIL drain: %0d entries left, expected 0", scoreboard.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control FSM for the MIPS datapath: sequences one instruction over 3–5 clock states (fetch, decode, execute, memory, writeback) instead of decoding `op` in a single cycle. Sits beside the shared ALU/register file/unified memory and drives their enables and mux selects. Supports R-type, lw, sw, beq, j and addi. Stalls on a memory-ready handshake and flags illegal opcodes.

## Interface
- No parameters. Opcode, state and ALUop encodings come from the shared package.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 6: opcode, IR[31:26], valid from DECODE onward.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current read/write this cycle.
- `PCWrite` out 1: unconditional PC load.
- `PCWriteCond` out 1: PC load if `zero`.
- `pc_en` out 1: `PCWrite | (PCWriteCond & zero)`.
- `IorD` out 1: memory address is 0 = PC, 1 = ALUOut.
- `MemRead`, `MemWrite` out 1 each: memory strobes.
- `IRWrite` out 1: instruction register load.
- `MemtoReg` out 1: writeback is 1 = MDR, 0 = ALUOut.
- `RegDst` out 1: destination is 1 = rd, 0 = rt.
- `RegWrite` out 1: register file write.
- `ALUSrcA` out 1: ALU A is 0 = PC, 1 = rs.
- `ALUSrcB` out 2: ALU B is 00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
- `ALUop` out 3: 000 = add, 001 = sub, 010 = funct-decoded.
- `PCSource` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `instr_done` out 1: one-cycle pulse on an instruction's final state.
- `illegal_op` out 1: one-cycle pulse on an unsupported opcode.
- `state` out 4: current state, for debug.

## Operation
- Moore FSM. All outputs decode from the state register, except `pc_en` (uses `zero`) and the FETCH/MEM gating by `mem_ready`.
- Unlisted outputs are 0 in every state.
- **FETCH(0)**: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=000. IRWrite, PCWrite and PCSource=00 are asserted only when `mem_ready`=1, and the FSM then goes to DECODE. Otherwise it holds in FETCH.
- **DECODE(1)**: ALUSrcA=0, ALUSrcB=11, ALUop=000 (precompute branch target). Next state by `op`:
  - 000000 → EXEC
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000 → ADDIEX
  - any other value → FETCH, with `illegal_op`=1 in this cycle.
- **MEMADR(2)**: ALUSrcA=1, ALUSrcB=10, ALUop=000. Goes to MEMRD for lw, MEMWR for sw.
- **MEMRD(3)**: MemRead=1, IorD=1. Holds until `mem_ready`, then goes to MEMWB.
- **MEMWB(4)**: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1 → FETCH.
- **MEMWR(5)**: MemWrite=1, IorD=1. Holds until `mem_ready`. In the `mem_ready` cycle: instr_done=1 → FETCH.
- **EXEC(6)**: ALUSrcA=1, ALUSrcB=00, ALUop=010 → RWB.
- **RWB(7)**: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1 → FETCH.
- **BRANCH(8)**: ALUSrcA=1, ALUSrcB=00, ALUop=001, PCWriteCond=1, PCSource=01, instr_done=1 → FETCH.
- **JUMP(9)**: PCWrite=1, PCSource=10, instr_done=1 → FETCH.
- **ADDIEX(10)**: ALUSrcA=1, ALUSrcB=10, ALUop=000 → ADDIWB.
- **ADDIWB(11)**: RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1 → FETCH.
- Unused state codes 12–15: all outputs 0, next state FETCH.

## Timing
- **Reset**: on any edge with `reset`=1, state ← FETCH. While `reset`=1, every output is forced to 0, including `pc_en`, `instr_done`, `illegal_op` and `state`. FETCH behaviour begins in the first cycle after `reset` drops.
- **Reset mid-instruction**: the instruction is abandoned with no further writes. A pending MemWrite is deasserted in the reset cycle.
- **Latency with `mem_ready` tied 1**: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4 cycles, counted FETCH through the `instr_done` cycle. Each cycle `mem_ready` is low adds one cycle in FETCH, MEMRD or MEMWR.
- **Handshake**: a strobe stays asserted with stable IorD until `mem_ready` is sampled 1. `mem_ready` is ignored in all other states.
- **`zero`**: sampled only in BRANCH.
- **`op`**: sampled only in DECODE and MEMADR. It must stay stable from IRWrite until the next FETCH.

## Structure
- Package `mips_ctrl_pkg` holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI)
  - the 4-bit state typedef with the codes 0–11 above
  - ALUop constants (ALU_ADD, ALU_SUB, ALU_FUNCT)
  - ALUSrcB and PCSource select constants.
- One sub-module, `mc_ctrl_outdec`: purely combinational, maps state (plus `mem_ready`) to the control word. The top holds the state register, the next-state logic, `pc_en` and the reset gating.

## Test plan
- **Reset**: hold `reset`=1 for 3 cycles mid-MEMWR → all outputs 0, including MemWrite in the first reset cycle. After release: state=0, MemRead=1, IorD=0.
- **R-type**: op=000000, `mem_ready`=1 → states 0,1,6,7. RWB has RegWrite=1, RegDst=1. instr_done pulses on cycle 4.
- **lw with wait**: op=100011, `mem_ready` low for 2 cycles in MEMRD → states 0,1,2,3,3,3,4 with MemRead and IorD=1 held throughout MEMRD. MemtoReg=1 and RegWrite=1 in state 4.
- **sw**: op=101011 → MemWrite=1 in state 5 only. RegWrite never asserted. 4 cycles total.
- **beq**: op=000100 with `zero`=1 → `pc_en`=1, PCSource=01 in BRANCH. Repeat with `zero`=0 → `pc_en`=0. Both take 3 cycles.
- **Illegal and jump**: op=111111 → `illegal_op` pulses in DECODE, no RegWrite or MemWrite, back to FETCH. Then op=000010 → PCWrite=1, PCSource=10 in state 9.
